grid_reader: RTL
================

Name: grid_reader

Overview:
- Read-side counterpart of the snake/food grid writer. The board memory is GRID_W x GRID_H cells of CELL_W bits, with codes 00 empty, 01 food, 10 snake, 11 reserved.
- On `start`, the block scans the whole board in row-major order and streams every cell, with its coordinates, to the renderer over a valid/ready handshake.
- It also serves single-cell probe lookups for the game controller (head-collision / food checks). Probes take priority over the scan.

Parameters:
- GRID_W, 16, cells per row (x range 0..GRID_W-1).
- GRID_H, 16, rows (y range 0..GRID_H-1).
- COORD_W, 4, width of the x/y coordinate buses.
- CELL_W, 2, width of one cell code.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a frame scan when idle.
- busy  out  1  high from start acceptance until the frame_done cycle inclusive.
- rd_en  out  1  board-memory read strobe.
- rd_x  out  COORD_W  read column.
- rd_y  out  COORD_W  read row.
- rd_data  in  CELL_W  cell code; valid exactly 1 cycle after rd_en.
- out_valid  out  1  streamed cell available.
- out_ready  in  1  renderer accepts the streamed cell.
- out_x  out  COORD_W  column of the streamed cell.
- out_y  out  COORD_W  row of the streamed cell.
- out_cell  out  CELL_W  code of the streamed cell.
- out_last  out  1  streamed cell is (GRID_W-1, GRID_H-1).
- frame_done  out  1  one-cycle pulse after the last handshake.
- probe_req  in  1  probe lookup request.
- probe_x  in  COORD_W  probe column.
- probe_y  in  COORD_W  probe row.
- probe_ack  out  1  one-cycle pulse; probe_cell valid.
- probe_cell  out  CELL_W  probed cell code; held until next ack.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; scan counters (sx, sy) = (0,0); return-state register = IDLE.
  - Reset wins over every other input in the same cycle.
  - Reset mid-scan or mid-probe aborts immediately: no handshake completes, no frame_done, no probe_ack.
- States:
  - IDLE: start=1 and no probe_req → sx=sy=0, busy=1, go SREAD.
  - SREAD: rd_en=1, rd_x=sx, rd_y=sy → SWAIT.
  - SWAIT: capture rd_data into out_cell, out_x=sx, out_y=sy, out_last=(sx==GRID_W-1 && sy==GRID_H-1); out_valid=1 → SHOLD.
  - SHOLD: out_valid held with all out_* stable until out_ready=1.
    - On handshake: out_valid=0.
    - If last → DONE.
    - Else advance: sx+1; if sx==GRID_W-1 then sx=0, sy+1. Go SREAD.
  - DONE: frame_done=1 for this single cycle, busy=0 next cycle → IDLE.
  - PWAIT: probe_ack=1, probe_cell=rd_data → return-state register.
- Probe arbitration:
  - probe_req is sampled only in IDLE and SREAD.
  - When sampled, that cycle drives rd_en=1, rd_x=probe_x, rd_y=probe_y instead of the scan read. The return state (IDLE or SREAD) is saved; go PWAIT.
  - The scan read is deferred, not lost. Scan latency grows by 2 cycles per probe.
  - Requester keeps probe_req/coords stable until probe_ack and must drop probe_req in the ack cycle. Back-to-back probes are allowed from the next cycle.
  - probe_req in SWAIT/SHOLD/DONE waits until a sampling state is reached. Maximum wait 3 cycles plus renderer stall.
  - start and probe_req together in IDLE: probe first, then start is lost unless still asserted on return to IDLE. The requester holds start until busy=1.
- start while busy is ignored.
- Coordinate arithmetic is COORD_W-bit unsigned. Counters never exceed GRID_W-1 / GRID_H-1; no wrap beyond the frame.
- Probe coordinates ≥ GRID_W/GRID_H are passed to memory unchecked; the result is undefined.
- Throughput: one cell per 3 cycles with out_ready tied high. Full 16x16 frame = 768 cycles from start acceptance to frame_done, no probes.
- rd_en is never asserted in SWAIT, SHOLD, PWAIT or DONE. At most one read is outstanding.

Test Plan:
- Memory preloaded with snake at (3,5),(4,5), food at (9,2), out_ready=1, pulse start → 256 handshakes in order (0,0),(1,0)…(15,15).
  - out_cell=10 at (3,5) and (4,5), 01 at (9,2), 00 elsewhere.
  - out_last only at (15,15); frame_done exactly 768 cycles after start; busy low next cycle.
- out_ready toggled randomly at 30% → identical 256-cell sequence; out_x/out_y/out_cell/out_last never change while out_valid=1 and out_ready=0.
- Idle probe (9,2) → probe_ack 2 cycles after probe_req with probe_cell=01; probe (0,0) back-to-back → probe_cell=00.
- Probe (4,5) asserted while scan is at SREAD for (7,0) → probe read issued first, probe_ack with 10; scan resumes at (7,0) with no skipped or duplicated cells; frame_done at 770.
- Reset asserted while SHOLD at (2,1) → next cycle all outputs 0, IDLE. A new start rescans from (0,0), and no stale frame_done is produced.
- start pulsed again at cell (10,3) mid-scan → ignored; exactly one frame_done per accepted start.

Source files
------------

// File: rtl/grid_reader.sv
// grid_reader: scans the snake/food board in row-major order and streams each
// cell with its coordinates over a valid/ready handshake. Single-cell probe
// lookups from the game controller take priority over the scan read.
//
// Handshake: out_valid rises with out_x/out_y/out_cell/out_last stable and
// stays high, with those fields unchanged, until the cycle in which out_ready
// is also high. That rising edge completes the transfer and out_valid drops.
//
// Board memory: rd_en/rd_x/rd_y select a cell and rd_data is valid exactly one
// cycle later. The read port is driven combinationally so that a probe
// sampled in IDLE or SREAD can replace the scan read in that same cycle. The
// deferred scan read is reissued when the FSM returns to SREAD.
module grid_reader #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 16,
    parameter int COORD_W = 4,
    parameter int CELL_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               rd_en,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    input  logic [CELL_W-1:0]  rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [CELL_W-1:0]  out_cell,
    output logic               out_last,
    output logic               frame_done,
    input  logic               probe_req,
    input  logic [COORD_W-1:0] probe_x,
    input  logic [COORD_W-1:0] probe_y,
    output logic               probe_ack,
    output logic [CELL_W-1:0]  probe_cell
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(GRID_H - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SREAD = 3'd1,
        SWAIT = 3'd2,
        SHOLD = 3'd3,
        DONE  = 3'd4,
        PWAIT = 3'd5
    } state_t;

    state_t             state_q;
    state_t             ret_q;
    logic [COORD_W-1:0] sx_q;
    logic [COORD_W-1:0] sy_q;
    logic               busy_q;
    logic               out_valid_q;
    logic [COORD_W-1:0] out_x_q;
    logic [COORD_W-1:0] out_y_q;
    logic [CELL_W-1:0]  out_cell_q;
    logic               out_last_q;
    logic               frame_done_q;
    logic               probe_ack_q;
    logic [CELL_W-1:0]  probe_cell_q;

    logic               probe_take;
    logic               scan_rd;

    // Read-port arbitration: a probe sampled in IDLE/SREAD steals this cycle's read.
    always_comb begin
        probe_take = !reset && probe_req && ((state_q == IDLE) || (state_q == SREAD));
        scan_rd    = !reset && (state_q == SREAD);
        rd_en      = probe_take || scan_rd;
        rd_x       = '0;
        rd_y       = '0;
        if (probe_take) begin
            rd_x = probe_x;
            rd_y = probe_y;
        end else if (scan_rd) begin
            rd_x = sx_q;
            rd_y = sy_q;
        end
    end

    // Scan/probe FSM with all handshake and status outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ret_q        <= IDLE;
            sx_q         <= '0;
            sy_q         <= '0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_cell_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            probe_ack_q  <= 1'b0;
            probe_cell_q <= '0;
        end else begin
            frame_done_q <= 1'b0;
            probe_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (probe_take) begin
                        ret_q   <= IDLE;
                        state_q <= PWAIT;
                    end else if (start) begin
                        sx_q    <= '0;
                        sy_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SREAD;
                    end
                end
                SREAD: begin
                    if (probe_take) begin
                        ret_q   <= SREAD;
                        state_q <= PWAIT;
                    end else begin
                        state_q <= SWAIT;
                    end
                end
                SWAIT: begin
                    out_cell_q  <= rd_data;
                    out_x_q     <= sx_q;
                    out_y_q     <= sy_q;
                    out_last_q  <= (sx_q == X_LAST) && (sy_q == Y_LAST);
                    out_valid_q <= 1'b1;
                    state_q     <= SHOLD;
                end
                SHOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            frame_done_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            if (sx_q == X_LAST) begin
                                sx_q <= '0;
                                sy_q <= sy_q + COORD_W'(1);
                            end else begin
                                sx_q <= sx_q + COORD_W'(1);
                            end
                            state_q <= SREAD;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                PWAIT: begin
                    probe_ack_q  <= 1'b1;
                    probe_cell_q <= rd_data;
                    state_q      <= ret_q;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_cell   = out_cell_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign probe_ack  = probe_ack_q;
    assign probe_cell = probe_cell_q;

endmodule
